// File: rtl/shift_rx.sv
// Serial-to-parallel receiver: MSB-first bits qualified by valid, framed by eos.
// Ports: clk, rst (sync, active-high); D, valid, eos serial side;
//        rd, clr_err from consumer; Q, full, busy, cnt, ferr, ovr outputs.
module shift_rx #(
    parameter int bits = 8,
    localparam int CW = $clog2(bits)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            D,
    input  logic            valid,
    input  logic            eos,
    input  logic            rd,
    input  logic            clr_err,
    output logic [bits-1:0] Q,
    output logic            full,
    output logic            busy,
    output logic [CW-1:0]   cnt,
    output logic            ferr,
    output logic            ovr
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(bits - 1);

    state_t          state;
    logic [bits-2:0] sreg;
    logic [bits-1:0] nxt;

    // Only bits-1 bits are ever held; the final bit goes straight into Q.
    assign nxt  = {sreg, D};
    assign busy = (state == SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sreg  <= '0;
            Q     <= '0;
            full  <= 1'b0;
            cnt   <= '0;
            ferr  <= 1'b0;
            ovr   <= 1'b0;
        end else begin
            // Read acknowledge; a completing word below overrides it.
            if (rd && full)
                full <= 1'b0;

            // Clear first so that an error raised this cycle wins.
            if (clr_err) begin
                ferr <= 1'b0;
                ovr  <= 1'b0;
            end

            if (valid) begin
                case (state)
                    IDLE: begin
                        if (eos) begin
                            ferr <= 1'b1;
                        end else begin
                            sreg  <= nxt[bits-2:0];
                            cnt   <= CW'(1);
                            state <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (cnt == LAST) begin
                            state <= IDLE;
                            cnt   <= '0;
                            if (!eos) begin
                                ferr <= 1'b1;
                            end else if (!full || rd) begin
                                Q    <= nxt;
                                full <= 1'b1;
                            end else begin
                                ovr <= 1'b1;
                            end
                        end else if (eos) begin
                            ferr  <= 1'b1;
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            sreg <= nxt[bits-2:0];
                            cnt  <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/shift_rx.md
Name: shift_rx

Overview:
- Serial-to-parallel receiver; the receiving end of the team's `shift` serializer link.
- Captures a MSB-first serial bit stream qualified by a per-bit strobe and checks framing against the transmitter's end-of-shift marker.
- Presents each complete word on a parallel output held until read, with sticky framing and overrun flags.
- Sits between a serial pin or serializer output and the parallel consumer logic in the tt_um top level.

Parameters:
- bits, 8, word width in bits; legal range 2..32.
- CW, $clog2(bits), width of the bit counter (derived, not overridden).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- D  input  1  serial data bit.
- valid  input  1  qualifies D and eos for one cycle; one bit per high cycle.
- eos  input  1  end-of-shift marker; must accompany the last bit of a word.
- rd  input  1  consumer read strobe; acknowledges the held word.
- clr_err  input  1  clears ferr and ovr.
- Q  output  bits  last good received word.
- full  output  1  Q holds an unread word.
- busy  output  1  word partially received (state SHIFT).
- cnt  output  CW  bits received in the current word.
- ferr  output  1  sticky framing error.
- ovr  output  1  sticky overrun error.

Behaviour:
- Reset (rst=1 at clk edge):
  - Q=0, full=0, busy=0, cnt=0, ferr=0, ovr=0.
  - Internal shift register cleared; state=IDLE.
  - Any partial word is discarded; reset overrides every other input.
- States:
  - IDLE: cnt=0.
  - SHIFT: 1 <= cnt <= bits-1.
- Cycles with valid=0: no state change; D and eos are ignored.
- Shifting: the shift register shifts left and D enters bit 0. The first received bit therefore lands in Q[bits-1].
- IDLE with valid=1:
  - eos=0: shift, cnt=1, go to SHIFT.
  - eos=1: set ferr, discard, stay in IDLE.
- SHIFT with valid=1 and cnt < bits-1:
  - eos=0: shift, cnt++.
  - eos=1: set ferr, discard the partial word, cnt=0, go to IDLE.
- SHIFT with valid=1 and cnt == bits-1 (final bit):
  - eos=0: set ferr, discard, go to IDLE.
  - eos=1 and (full=0 or rd=1 this cycle): Q <= {sreg[bits-2:0], D}, full=1, go to IDLE.
  - eos=1 and full=1 and rd=0: set ovr, drop the new word, leave Q unchanged, full stays 1, go to IDLE.
- Latency: Q and full update on the same clock edge that samples the final bit, so they are visible the following cycle.
- rd behaviour:
  - rd=1 with full=1 and no completion that cycle: full=0 next cycle; Q keeps its value.
  - rd=1 with full=0: ignored.
- clr_err=1: ferr=0 and ovr=0 next cycle. If an error event occurs in the same cycle, the set wins.
- busy = (state == SHIFT). cnt is registered.
- No timeout: a partial word waits indefinitely for more valid bits.

Test Plan:
- Nominal word (bits=8): after reset, send 0xA5 MSB-first (1,0,1,0,0,1,0,1) on 8 consecutive valid cycles, eos=1 on bit 8 only.
  - Expect cycle after bit 8: Q=0xA5, full=1, busy=0, cnt=0, ferr=0.
  - Pulse rd: expect full=0, Q still 0xA5.
- Gapped strobe: send 0x3C with valid=0 gaps of 0–3 random cycles between bits.
  - Expect cnt stepping 1..7 during reception, then Q=0x3C, full=1.
  - Expect D toggling during valid=0 cycles to have no effect.
- Framing errors:
  - eos=1 on bit 5: expect ferr=1, cnt=0, busy=0, Q/full unchanged.
  - Then a word with eos=0 on bit 8: expect ferr remains 1, no load.
  - Pulse clr_err: expect ferr=0.
- Overrun and read-same-cycle:
  - Receive 0x11 and leave it unread; receive 0x22: expect ovr=1, Q=0x11, full=1.
  - Receive 0x33 with rd=1 on the final-bit cycle: expect Q=0x33, full=1, no new overrun.
- Reset mid-word: after 4 bits of 0xF0, assert rst for one cycle.
  - Expect all outputs 0.
  - Then send full 0x81: expect Q=0x81 with no leftover bits.
- Error priority: on the cycle a framing error is detected, assert clr_err=1.
  - Expect ferr=1 the next cycle.
